// File: rtl/audio_wb_dma.sv
// audio_wb_dma: Wishbone B4 pipelined DMA master moving stereo sample pairs from memory into the audio FIFO registers.
// Ports:
//    clk, rst_n                : clock, synchronous active-low reset
//    start, abort              : transfer control pulses
//    base_addr, sample_count   : first pair address (8-byte aligned internally), pair count
//    fifo_full                 : audio FIFO has no room
//    wb_*                      : Wishbone B4 pipelined master port
//    busy, done, error, remaining : status (done is a pulse, error is sticky)
module audio_wb_dma #(
   parameter logic [31:0] AUDIO_BASE = 32'h0001_0000,
   parameter int          TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] base_addr,
   input  logic [15:0] sample_count,
   input  logic        fifo_full,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_stall_i,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] remaining
);
   typedef enum logic [2:0] {IDLE, RD_L, RD_R, WAIT_FIFO, WR_L, WR_R} state_t;
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t        r_state;
   logic          r_cyc, r_stb, r_we, r_busy, r_done, r_error, r_issued, r_abort;
   logic [31:0]   r_adr, r_dat, r_addr;
   logic [23:0]   r_left, r_right;
   logic [15:0]   r_rem;
   logic [TW-1:0] r_tmr;
   logic          w_ack, w_accept, w_stop, w_unused;
   logic [31:0]   w_addr0;
   state_t        w_next;
   // {we, adr, dat} of the single request a bus state issues
   function automatic logic [64:0] f_req(input state_t s);
      return (s == RD_L) ? {1'b0, r_addr, 32'h0} :
             (s == RD_R) ? {1'b0, r_addr + 32'd4, 32'h0} :
             (s == WR_L) ? {1'b1, AUDIO_BASE + 32'h10, 8'h00, r_left} :
                           {1'b1, AUDIO_BASE + 32'h14, 8'h80, r_right};
   endfunction
   assign w_ack    = r_cyc & wb_ack_i;
   assign w_accept = r_stb & ~wb_stall_i;
   assign w_stop   = abort | r_abort;
   assign w_addr0  = {base_addr[31:3], 3'b000};
   assign w_unused = ^{wb_dat_i[31:24], base_addr[2:0]};
   assign w_next   = (r_state == RD_L) ? RD_R :
                     (r_state == RD_R) ? WAIT_FIFO :
                     (r_state == WR_L) ? WR_R :
                     (r_rem == 16'd1)  ? IDLE : RD_L;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cyc    <= 1'b0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_adr    <= 32'h0;
         r_dat    <= 32'h0;
         r_addr   <= 32'h0;
         r_left   <= 24'h0;
         r_right  <= 24'h0;
         r_rem    <= 16'h0;
         r_tmr    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_issued <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort && r_busy) r_abort <= 1'b1;
         case (r_state)
            IDLE: begin
               if (start && sample_count == 16'd0) r_done <= 1'b1;
               else if (start) begin
                  r_state  <= RD_L;
                  r_addr   <= w_addr0;
                  r_rem    <= sample_count;
                  r_error  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_abort  <= 1'b0;
                  r_cyc    <= 1'b1;
                  r_stb    <= 1'b1;
                  r_we     <= 1'b0;
                  r_adr    <= w_addr0;
                  r_dat    <= 32'h0;
                  r_issued <= 1'b1;
               end
            end
            WAIT_FIFO: begin
               if (w_stop) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_abort <= 1'b0;
               end else if (!fifo_full) begin
                  r_state  <= WR_L;
                  r_cyc    <= 1'b1;
                  r_stb    <= 1'b1;
                  {r_we, r_adr, r_dat} <= f_req(WR_L);
                  r_issued <= 1'b1;
               end
            end
            default: begin
               // after an ack the next state is entered with cyc low, giving the mandatory idle cycle
               if (!r_issued) begin
                  r_cyc    <= 1'b1;
                  r_stb    <= 1'b1;
                  {r_we, r_adr, r_dat} <= f_req(r_state);
                  r_issued <= 1'b1;
               end else if (w_ack) begin
                  r_cyc    <= 1'b0;
                  r_stb    <= 1'b0;
                  r_issued <= 1'b0;
                  if (r_state == RD_L) r_left <= wb_dat_i[23:0];
                  if (r_state == RD_R) r_right <= wb_dat_i[23:0];
                  if (r_state == WR_R) begin
                     r_rem  <= r_rem - 16'd1;
                     r_addr <= r_addr + 32'd8;
                  end
                  r_state <= w_stop ? IDLE : w_next;
                  if (w_stop || w_next == IDLE) begin
                     r_busy  <= 1'b0;
                     r_abort <= 1'b0;
                  end
                  r_done <= !w_stop && w_next == IDLE;
               end else if (w_accept) begin
                  r_stb <= 1'b0;
                  r_tmr <= TW'(1);
               end else if (!r_stb && r_tmr == TW'(TIMEOUT)) begin
                  r_cyc    <= 1'b0;
                  r_issued <= 1'b0;
                  r_error  <= 1'b1;
                  r_busy   <= 1'b0;
                  r_abort  <= 1'b0;
                  r_state  <= IDLE;
               end else if (!r_stb) r_tmr <= r_tmr + TW'(1);
            end
         endcase
      end
   end
   assign wb_cyc_o  = r_cyc;
   assign wb_stb_o  = r_stb;
   assign wb_we_o   = r_we;
   assign wb_adr_o  = r_adr;
   assign wb_dat_o  = r_dat;
   assign wb_sel_o  = 4'hF;
   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;
   assign remaining = r_rem;
endmodule
